// File: rtl/pe_dot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_dot_ctrl_pkg
//   Shared definitions for the serial dot-product sequencer:
//   - state_t              : controller FSM encoding (IDLE/RUN/OUT)
//   - DEF_*_WIDTH          : default operand, result and length widths
// -----------------------------------------------------------------------------
package pe_dot_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   localparam int unsigned DEF_ACT_WIDTH    = 16;
   localparam int unsigned DEF_WGT_WIDTH    = 16;
   localparam int unsigned DEF_PE_OUT_WIDTH = DEF_ACT_WIDTH + DEF_WGT_WIDTH;
   localparam int unsigned DEF_LEN_WIDTH    = 16;

endpackage : pe_dot_ctrl_pkg

// File: rtl/pe_dot_ctrl_pe.sv
// -----------------------------------------------------------------------------
// pe
//   Single registered processing element. Each rising edge it loads
//   y <= c + a*b ("FMA") or y <= c - a*b ("FMS"). The product is full signed
//   width; the sum wraps modulo 2^Y_WIDTH with no saturation.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, clears the result register
//   i_a    in   A_WIDTH  signed multiplicand
//   i_b    in   B_WIDTH  signed multiplier
//   i_c    in   Y_WIDTH  signed addend (accumulate input)
//   o_y    out  Y_WIDTH  signed registered result
// -----------------------------------------------------------------------------
module pe
   import pe_dot_ctrl_pkg::*;
#(
   parameter          PE_MODE = "FMA",
   parameter int unsigned A_WIDTH = DEF_ACT_WIDTH,
   parameter int unsigned B_WIDTH = DEF_WGT_WIDTH,
   parameter int unsigned Y_WIDTH = DEF_PE_OUT_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [A_WIDTH-1:0] i_a,
   input  logic signed [B_WIDTH-1:0] i_b,
   input  logic signed [Y_WIDTH-1:0] i_c,
   output logic signed [Y_WIDTH-1:0] o_y
);

   logic signed [A_WIDTH+B_WIDTH-1:0] w_prod;
   logic signed [Y_WIDTH-1:0]         w_prod_ext;
   logic signed [Y_WIDTH-1:0]         w_y_next;
   logic signed [Y_WIDTH-1:0]         r_y;

   assign w_prod     = i_a * i_b;
   // Signed size cast: sign-extends (or truncates) the product to the sum width.
   assign w_prod_ext = Y_WIDTH'(w_prod);

   generate
      if (PE_MODE == "FMA") begin : g_fma
         assign w_y_next = i_c + w_prod_ext;
      end else begin : g_fms
         assign w_y_next = i_c - w_prod_ext;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_y <= '0;
      end else begin
         r_y <= w_y_next;
      end
   end

   assign o_y = r_y;

endmodule : pe

// File: rtl/pe_dot_ctrl.sv
// -----------------------------------------------------------------------------
// pe_dot_ctrl
//   Drives one FMA processing element through a signed dot product of
//   programmable length. Operand pairs arrive on a valid/ready stream; the
//   PE accumulate input is steered between zero (IDLE) and its own output
//   (RUN/OUT), so the PE register itself is the accumulator. The final sum is
//   presented straight from the PE register on a valid/ready result port.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a reduction (sampled only in IDLE)
//   cfg_len    in   LEN_WIDTH  pair count, latched on accepted start
//   busy       out  high in RUN and OUT
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair accepted when in_valid && in_ready
//   in_act     in   ACT_WIDTH  signed activation
//   in_wgt     in   WGT_WIDTH  signed weight
//   out_valid  out  result valid
//   out_ready  in   result consumed when out_valid && out_ready
//   out_data   out  PE_OUT_WIDTH  signed dot-product result
// -----------------------------------------------------------------------------
module pe_dot_ctrl
   import pe_dot_ctrl_pkg::*;
#(
   parameter int unsigned ACT_WIDTH    = DEF_ACT_WIDTH,
   parameter int unsigned WGT_WIDTH    = DEF_WGT_WIDTH,
   parameter int unsigned PE_OUT_WIDTH = ACT_WIDTH + WGT_WIDTH,
   parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [LEN_WIDTH-1:0]           cfg_len,
   output logic                           busy,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [ACT_WIDTH-1:0]    in_act,
   input  logic signed [WGT_WIDTH-1:0]    in_wgt,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [PE_OUT_WIDTH-1:0] out_data
);

   state_t                         r_state;
   state_t                         w_next;
   logic [LEN_WIDTH-1:0]           r_len;
   logic [LEN_WIDTH-1:0]           r_cnt;
   logic                           w_in_hs;
   logic                           w_out_hs;
   logic                           w_last;
   logic signed [ACT_WIDTH-1:0]    w_pe_a;
   logic signed [WGT_WIDTH-1:0]    w_pe_b;
   logic signed [PE_OUT_WIDTH-1:0] w_pe_c;
   logic signed [PE_OUT_WIDTH-1:0] w_pe_y;

   assign w_in_hs  = in_valid  && in_ready;
   assign w_out_hs = out_valid && out_ready;
   // r_len is never 0 while in RUN, so len-1 cannot underflow there.
   assign w_last   = (r_cnt == (r_len - LEN_WIDTH'(1)));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (cfg_len == '0) ? ST_OUT : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_in_hs && w_last) begin
               w_next = ST_OUT;
            end
         end
         ST_OUT: begin
            if (w_out_hs) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs and PE operand muxes ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      w_pe_a    = '0;
      w_pe_b    = '0;
      w_pe_c    = '0;
      unique case (r_state)
         ST_IDLE: begin
            // a=b=c=0: PE register clears every idle cycle.
         end
         ST_RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            w_pe_c   = w_pe_y;
            // Without a handshake a*b=0, so the feedback holds the sum.
            if (w_in_hs) begin
               w_pe_a = in_act;
               w_pe_b = in_wgt;
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            w_pe_c    = w_pe_y;
         end
         default: begin
         end
      endcase
   end

   // ---------------- Length latch and beat counter ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len <= '0;
         r_cnt <= '0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_len <= cfg_len;
            r_cnt <= '0;
         end else if ((r_state == ST_RUN) && w_in_hs) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
         end
      end
   end

   // ---------------- Processing element ----------------
   pe #(
      .PE_MODE ("FMA"),
      .A_WIDTH (ACT_WIDTH),
      .B_WIDTH (WGT_WIDTH),
      .Y_WIDTH (PE_OUT_WIDTH)
   ) u_pe (
      .clk   (clk),
      .reset (reset),
      .i_a   (w_pe_a),
      .i_b   (w_pe_b),
      .i_c   (w_pe_c),
      .o_y   (w_pe_y)
   );

   assign out_data = w_pe_y;

endmodule : pe_dot_ctrl

// File: tb/tb_pe_dot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_dot_ctrl
//   Directed bench for pe_dot_ctrl at default widths. Inputs change 1 time
//   unit after a rising edge; outputs are checked at the same point, so a
//   check right after edge k observes cycle k+1.
// -----------------------------------------------------------------------------
module tb_pe_dot_ctrl;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [15:0]        cfg_len;
   logic               busy;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_act;
   logic signed [15:0] in_wgt;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pe_dot_ctrl #(
      .ACT_WIDTH    (16),
      .WGT_WIDTH    (16),
      .PE_OUT_WIDTH (32),
      .LEN_WIDTH    (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_act    (in_act),
      .in_wgt    (in_wgt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic signed [15:0] a, input logic signed [15:0] w);
      in_valid = 1'b1;
      in_act   = a;
      in_wgt   = w;
      tick();
      in_valid = 1'b0;
      in_act   = 16'sh5A5A;
      in_wgt   = 16'sh5A5A;
   endtask

   task automatic go(input logic [15:0] len);
      start   = 1'b1;
      cfg_len = len;
      tick();
      start   = 1'b0;
      cfg_len = 16'hFFFF;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      cfg_len   = '0;
      in_valid  = 1'b0;
      in_act    = '0;
      in_wgt    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_out_data",  out_data,  0);

      // Basic: 1*2+3*4+5*6+7*8 = 100, out_valid in cycle s+5
      go(16'd4);
      chk("basic_in_ready_s1", in_ready, 1);
      chk("basic_busy_s1",     busy,     1);
      beat(1, 2);
      beat(3, 4);
      beat(5, 6);
      chk("basic_no_valid_s4", out_valid, 0);
      beat(7, 8);
      chk("basic_valid_s5",    out_valid, 1);
      chk("basic_data",        out_data,  100);
      chk("basic_in_ready_s5", in_ready,  0);
      tick();
      chk("basic_pulse_end",   out_valid, 0);
      chk("basic_idle_busy",   busy,      0);
      chk("basic_gap_ready",   in_ready,  0);

      // Signed with two-cycle bubbles: -15 -8 +7 = -16, valid in cycle s+8
      go(16'd3);
      beat(-3, 5);
      tick();
      tick();
      beat(4, -2);
      tick();
      chk("bub_hold_sum",  out_data,  -23);
      chk("bub_hold_rdy",  in_ready,  1);
      tick();
      beat(-1, -7);
      chk("bub_valid_s8",  out_valid, 1);
      chk("bub_data",      out_data,  -16);
      tick();
      chk("bub_idle",      out_valid, 0);

      // Zero length: valid in cycle s+1 with 0, no in_ready
      go(16'd0);
      chk("zero_valid_s1", out_valid, 1);
      chk("zero_data",     out_data,  0);
      chk("zero_no_ready", in_ready,  0);
      tick();
      chk("zero_idle",     busy,      0);

      // start pulsed during RUN with a different length is ignored
      go(16'd2);
      start   = 1'b1;
      cfg_len = 16'd5;
      beat(2, 3);
      start   = 1'b0;
      chk("ign_still_run", in_ready, 1);
      beat(4, 5);
      chk("ign_valid",     out_valid, 1);
      chk("ign_data",      out_data,  26);
      tick();
      chk("ign_idle",      busy,      0);

      // Back-pressure: 500 held for 6 valid cycles, in_ready low throughout
      out_ready = 1'b0;
      go(16'd2);
      beat(10, 10);
      beat(20, 20);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_data",  out_data,  500);
         chk("bp_ready", in_ready,  0);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_valid_last", out_valid, 1);
      chk("bp_data_last",  out_data,  500);
      tick();
      chk("bp_done",       out_valid, 0);

      // Wrap: 3 * 2^30 mod 2^32 = 0xC0000000
      go(16'd3);
      beat(-32768, -32768);
      beat(-32768, -32768);
      beat(-32768, -32768);
      chk("wrap_valid", out_valid, 1);
      chk("wrap_data",  out_data,  32'hC000_0000);
      tick();

      // Reset mid-RUN after 2 of 4 beats, then a clean len=1 reduction
      go(16'd4);
      beat(9, 9);
      beat(9, 9);
      chk("mid_partial", out_data, 162);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_ready", in_ready,  0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy",  busy,      0);
      chk("mid_rst_data",  out_data,  0);
      go(16'd1);
      beat(6, 7);
      chk("mid_new_valid", out_valid, 1);
      chk("mid_new_data",  out_data,  42);

      // Reset while holding in OUT under back-pressure
      out_ready = 1'b0;
      tick();
      chk("out_hold_valid", out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      chk("out_rst_valid", out_valid, 0);
      chk("out_rst_data",  out_data,  0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pe_dot_ctrl
